// File: rtl/pixel_serial_streamer_pkg.sv
// pixel_serial_streamer_pkg: frame geometry, Q8.8 constants and the state encoding shared with the pixel loader.
package pixel_serial_streamer_pkg;
    localparam int PIXEL_COUNT = 784;
    localparam logic signed [15:0] Q_ONE = 16'sh0100;
    localparam logic signed [15:0] Q_HALF = 16'sh0080;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUANT = 2'd1,
        ST_DRAIN = 2'd2
    } pix_state_t;
    typedef struct packed {
        logic last;
        logic value;
    } pix_word_t;
endpackage

// File: rtl/pixel_serial_streamer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data; rd_valid follows an accepted rd_en by one cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0] count;
    logic do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign full = count == (ADDR_WIDTH+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr <= do_wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_rd ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
            rd_valid <= do_rd;
            if (do_rd) rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/pixel_serial_streamer.sv
// pixel_serial_streamer: thresholds a Q8.8 frame to one bit per pixel and streams the bits
// over a valid/ready link through a bit FIFO, flagging the last pixel of each frame.
module pixel_serial_streamer #(
    parameter int PIXEL_COUNT = pixel_serial_streamer_pkg::PIXEL_COUNT,
    parameter int DATA_WIDTH = 16,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = 16'sh0080,
    parameter int FIFO_DEPTH = 1024,
    parameter int FIFO_ADDR_W = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_valid,
    output logic                              frame_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] frame_flat,
    output logic                              frame_release,
    output logic                              pixel_bit,
    output logic                              pixel_last,
    output logic                              pixel_bit_valid,
    input  logic                              pixel_bit_ready,
    output logic                              tx_done
);
    import pixel_serial_streamer_pkg::*;

    localparam int IDX_W = $clog2(PIXEL_COUNT);
    localparam int SEL_W = $clog2(DATA_WIDTH * PIXEL_COUNT);

    pix_state_t state, state_n;
    logic [IDX_W-1:0] idx;
    logic [SEL_W-1:0] base;
    logic signed [DATA_WIDTH-1:0] px;
    pix_word_t wr_word, rd_word;
    logic wr_en, rd_en, rd_valid, rd_pend, fifo_full, fifo_empty, px_last, hs;

    assign base = SEL_W'(idx) * SEL_W'(DATA_WIDTH);
    assign px = frame_flat[base +: DATA_WIDTH];
    assign px_last = idx == IDX_W'(PIXEL_COUNT - 1);
    assign wr_word = '{last: px_last, value: px >= THRESHOLD};
    assign hs = pixel_bit_valid && pixel_bit_ready;
    // At most one read outstanding, so rd_valid always lands in an empty output register.
    assign rd_en = !fifo_empty && !rd_pend && (!pixel_bit_valid || pixel_bit_ready);

    always_comb begin
        state_n = state;
        frame_ready = 1'b0;
        wr_en = 1'b0;
        frame_release = 1'b0;
        case (state)
            ST_IDLE: begin
                frame_ready = 1'b1;
                state_n = frame_valid ? ST_QUANT : ST_IDLE;
            end
            ST_QUANT: begin
                wr_en = !fifo_full;
                frame_release = wr_en && px_last;
                state_n = frame_release ? ST_DRAIN : ST_QUANT;
            end
            ST_DRAIN: state_n = (hs && pixel_last) ? ST_IDLE : ST_DRAIN;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx <= '0;
            rd_pend <= 1'b0;
            pixel_bit <= 1'b0;
            pixel_last <= 1'b0;
            pixel_bit_valid <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state <= state_n;
            idx <= frame_release ? '0 : wr_en ? idx + 1'b1 : idx;
            rd_pend <= rd_en ? 1'b1 : rd_valid ? 1'b0 : rd_pend;
            pixel_bit_valid <= rd_valid || (pixel_bit_valid && !pixel_bit_ready);
            if (rd_valid) {pixel_last, pixel_bit} <= rd_word;
            tx_done <= hs && pixel_last;
        end
    end

    sync_fifo #(
        .DATA_WIDTH(2),
        .DEPTH(FIFO_DEPTH),
        .ADDR_WIDTH(FIFO_ADDR_W)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_word),
        .rd_en(rd_en),
        .rd_data(rd_word),
        .rd_valid(rd_valid),
        .full(fifo_full),
        .empty(fifo_empty)
    );
endmodule

// File: tb/tb_pixel_serial_streamer.sv
// tb_pixel_serial_streamer: random and patterned frames checked against a per-pixel threshold model;
// a second instance with a 16-deep FIFO exercises quantizer stalls.
module tb_pixel_serial_streamer;
    localparam int N = 784;
    localparam int DW = 16;

    logic clk = 1'b0, rst = 1'b1, fv = 1'b0, rdy = 1'b1, sel = 1'b0;
    logic [DW*N-1:0] flat = '0;
    logic fv_a, fv_b, rdy_a, rdy_b;
    logic fr_a, fr_b, rel_a, rel_b, bit_a, bit_b, last_a, last_b, v_a, v_b, txd_a, txd_b;
    logic m_fr, m_rel, m_bit, m_last, m_v, m_txd;
    logic p_v = 1'b0, p_rdy = 1'b0, p_bit = 1'b0, p_last = 1'b0;
    int cyc = 0, stab_err = 0, n_chk = 0, n_fail = 0, rdy_mode = 0, rdy_until = 0;
    int acc_q[$], rel_q[$], txd_q[$], hs_cyc_q[$];
    logic txd_fr_q[$];
    logic [1:0] hs_q[$], exp_q[$];

    assign fv_a = fv && !sel;
    assign fv_b = fv && sel;
    assign rdy_a = sel ? 1'b1 : rdy;
    assign rdy_b = sel ? rdy : 1'b1;
    assign m_fr = sel ? fr_b : fr_a;
    assign m_rel = sel ? rel_b : rel_a;
    assign m_bit = sel ? bit_b : bit_a;
    assign m_last = sel ? last_b : last_a;
    assign m_v = sel ? v_b : v_a;
    assign m_txd = sel ? txd_b : txd_a;

    pixel_serial_streamer dut_a (
        .clk(clk), .rst(rst), .frame_valid(fv_a), .frame_ready(fr_a), .frame_flat(flat),
        .frame_release(rel_a), .pixel_bit(bit_a), .pixel_last(last_a), .pixel_bit_valid(v_a),
        .pixel_bit_ready(rdy_a), .tx_done(txd_a)
    );

    pixel_serial_streamer #(.FIFO_DEPTH(16), .FIFO_ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .frame_valid(fv_b), .frame_ready(fr_b), .frame_flat(flat),
        .frame_release(rel_b), .pixel_bit(bit_b), .pixel_last(last_b), .pixel_bit_valid(v_b),
        .pixel_bit_ready(rdy_b), .tx_done(txd_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Events are logged at the falling edge with the index of the cycle they occur in.
    always @(negedge clk) begin
        if (!rst) begin
            if (fv && m_fr) acc_q.push_back(cyc);
            if (m_rel) rel_q.push_back(cyc);
            if (m_txd) begin
                txd_q.push_back(cyc);
                txd_fr_q.push_back(m_fr);
            end
            if (m_v && rdy) begin
                hs_q.push_back({m_last, m_bit});
                hs_cyc_q.push_back(cyc);
            end
            if (p_v && !p_rdy && (!m_v || m_bit !== p_bit || m_last !== p_last)) stab_err <= stab_err + 1;
        end
        p_v <= m_v && !rst;
        p_rdy <= rdy;
        p_bit <= m_bit;
        p_last <= m_last;
    end

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = cyc >= rdy_until;
                2: rdy = (cyc % 7) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic clear_q();
        acc_q.delete(); rel_q.delete(); txd_q.delete(); txd_fr_q.delete();
        hs_q.delete(); hs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic load_frame(input int pat);
        logic [15:0] p;
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: p = 16'h0100;
                1: p = (i % 3 == 0) ? 16'h0080 : (i % 3 == 1) ? 16'h007F : 16'hFF00;
                default: p = $urandom_range(0, 1) ? 16'(32'h80 + $urandom_range(0, 6) - 3) : 16'($urandom);
            endcase
            flat = {p, flat[DW*N-1:DW]};
            exp_q.push_back({i == N - 1, $signed(p) >= 16'sh0080});
        end
    endtask

    task automatic start_frame(output int t, output bit ok);
        int n0;
        n0 = acc_q.size();
        ok = 1'b0;
        @(posedge clk);
        #1 fv = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            #1 ok = acc_q.size() > n0;
        end
        @(posedge clk);
        #1 fv = 1'b0;
        t = ok ? acc_q[acc_q.size()-1] : 0;
    endtask

    task automatic wait_txd(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            #1 ok = txd_q.size() >= n;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic int stream_mm();
        int m = (hs_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++) if (hs_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk += 6;
        if (v_a !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", v_a); end
        if (bit_a !== 1'b0) begin n_fail++; $display("FAIL reset bit: got %b want 0", bit_a); end
        if (last_a !== 1'b0) begin n_fail++; $display("FAIL reset last: got %b want 0", last_a); end
        if (rel_a !== 1'b0) begin n_fail++; $display("FAIL reset release: got %b want 0", rel_a); end
        if (txd_a !== 1'b0) begin n_fail++; $display("FAIL reset tx_done: got %b want 0", txd_a); end
        if (fr_a !== 1'b1) begin n_fail++; $display("FAIL reset frame_ready: got %b want 1", fr_a); end
        clear_q();
        rst = 1'b0;
    endtask

    task automatic test_all_ones();
        int t;
        bit ok, done;
        sel = 1'b0; rdy_mode = 0; clear_q();
        load_frame(0);
        start_frame(t, ok);
        wait_txd(1, 4000, done);
        n_chk += 8;
        if (!ok || !done) begin n_fail++; $display("FAIL ones progress: accept %b done %b want 1 1", ok, done); end
        if (hs_q.size() !== N) begin n_fail++; $display("FAIL ones count: got %0d want %0d", hs_q.size(), N); end
        if (stream_mm() !== 0) begin n_fail++; $display("FAIL ones stream: %0d mismatches want 0", stream_mm()); end
        if (txd_q.size() !== 1) begin n_fail++; $display("FAIL ones tx_done count: got %0d want 1", txd_q.size()); end
        if (hs_cyc_q.size() == 0 || hs_cyc_q[0] !== t + 4) begin n_fail++; $display("FAIL ones first valid: got %0d want %0d", hs_cyc_q.size() ? hs_cyc_q[0] - t : -1, 4); end
        if (rel_q.size() !== 1 || rel_q[0] !== t + N) begin n_fail++; $display("FAIL ones release: got %0d pulses first at +%0d want 1 at +%0d", rel_q.size(), rel_q.size() ? rel_q[0] - t : -1, N); end
        if (txd_q.size() == 0 || hs_cyc_q.size() == 0 || txd_q[0] !== hs_cyc_q[hs_cyc_q.size()-1] + 1) begin n_fail++; $display("FAIL ones tx_done timing: not one cycle after last handshake"); end
        if (txd_fr_q.size() == 0 || txd_fr_q[0] !== 1'b1) begin n_fail++; $display("FAIL ones ready at tx_done: got %b want 1", txd_fr_q.size() ? txd_fr_q[0] : 1'b0); end
    endtask

    task automatic test_boundary();
        int t;
        bit ok, done;
        sel = 1'b0; rdy_mode = 0; clear_q();
        load_frame(1);
        start_frame(t, ok);
        wait_txd(1, 4000, done);
        n_chk += 3;
        if (!ok || !done) begin n_fail++; $display("FAIL boundary progress: accept %b done %b want 1 1", ok, done); end
        if (stream_mm() !== 0) begin n_fail++; $display("FAIL boundary stream: %0d mismatches want 0", stream_mm()); end
        if (txd_q.size() !== 1) begin n_fail++; $display("FAIL boundary tx_done count: got %0d want 1", txd_q.size()); end
    endtask

    task automatic test_backpressure();
        int t, s0;
        bit ok, done;
        sel = 1'b0; rdy_until = 1 << 30; rdy_mode = 1; clear_q();
        s0 = stab_err;
        load_frame(2);
        start_frame(t, ok);
        rdy_until = t + 1500;
        wait_txd(1, 5000, done);
        n_chk += 5;
        if (!ok || !done) begin n_fail++; $display("FAIL backpressure progress: accept %b done %b want 1 1", ok, done); end
        if (stream_mm() !== 0) begin n_fail++; $display("FAIL backpressure stream: %0d mismatches want 0", stream_mm()); end
        if (rel_q.size() !== 1 || rel_q[0] !== t + N) begin n_fail++; $display("FAIL backpressure release: got +%0d want +%0d", rel_q.size() ? rel_q[0] - t : -1, N); end
        if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL backpressure stability: %0d violations want 0", stab_err - s0); end
        if (hs_cyc_q.size() == 0 || hs_cyc_q[0] < t + 1500) begin n_fail++; $display("FAIL backpressure early handshake at +%0d", hs_cyc_q.size() ? hs_cyc_q[0] - t : -1); end
    endtask

    task automatic test_stall();
        int t, s0;
        bit ok, done;
        sel = 1'b1; rdy_mode = 2; clear_q();
        repeat (2) @(posedge clk);
        s0 = stab_err;
        load_frame(2);
        start_frame(t, ok);
        wait_txd(1, 8000, done);
        n_chk += 5;
        if (!ok || !done) begin n_fail++; $display("FAIL stall progress: accept %b done %b want 1 1", ok, done); end
        if (stream_mm() !== 0) begin n_fail++; $display("FAIL stall stream: %0d mismatches want 0", stream_mm()); end
        if (rel_q.size() !== 1 || rel_q[0] <= t + N) begin n_fail++; $display("FAIL stall release: got +%0d want later than +%0d", rel_q.size() ? rel_q[0] - t : -1, N); end
        if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL stall stability: %0d violations want 0", stab_err - s0); end
        if (txd_q.size() !== 1) begin n_fail++; $display("FAIL stall tx_done count: got %0d want 1", txd_q.size()); end
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0, ok2 = 1'b0, done;
        sel = 1'b0; rdy_mode = 0; clear_q();
        load_frame(2);
        @(posedge clk);
        #1 fv = 1'b1;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            #1 ok = rel_q.size() >= 1;
        end
        @(posedge clk);
        #1 load_frame(2);
        for (int k = 0; k < 3000 && !ok2; k++) begin
            @(negedge clk);
            #1 ok2 = acc_q.size() >= 2;
        end
        @(posedge clk);
        #1 fv = 1'b0;
        wait_txd(2, 4000, done);
        n_chk += 5;
        if (!ok || !ok2 || !done) begin n_fail++; $display("FAIL b2b progress: release %b accept2 %b done %b want 1 1 1", ok, ok2, done); end
        if (acc_q.size() < 2 || txd_q.size() == 0 || acc_q[1] !== txd_q[0]) begin n_fail++; $display("FAIL b2b second accept: got %0d want %0d", acc_q.size() > 1 ? acc_q[1] : -1, txd_q.size() ? txd_q[0] : -1); end
        if (txd_q.size() !== 2) begin n_fail++; $display("FAIL b2b tx_done count: got %0d want 2", txd_q.size()); end
        if (hs_q.size() !== 2 * N) begin n_fail++; $display("FAIL b2b count: got %0d want %0d", hs_q.size(), 2 * N); end
        if (stream_mm() !== 0) begin n_fail++; $display("FAIL b2b stream: %0d mismatches want 0", stream_mm()); end
    endtask

    task automatic test_reset_midframe();
        int t;
        bit ok, reached = 1'b0, done;
        sel = 1'b0; rdy_mode = 0; clear_q();
        load_frame(2);
        start_frame(t, ok);
        for (int k = 0; k < 2000 && !reached; k++) begin
            @(negedge clk);
            #1 reached = hs_q.size() >= 300;
        end
        #2 rst = 1'b1;
        #1;
        n_chk += 8;
        if (!ok || !reached) begin n_fail++; $display("FAIL midrst progress: accept %b reached %b want 1 1", ok, reached); end
        if (v_a !== 1'b0 || bit_a !== 1'b0 || last_a !== 1'b0) begin n_fail++; $display("FAIL midrst outputs: valid %b bit %b last %b want 0 0 0", v_a, bit_a, last_a); end
        if (fr_a !== 1'b1) begin n_fail++; $display("FAIL midrst frame_ready: got %b want 1", fr_a); end
        if (rel_a !== 1'b0 || txd_a !== 1'b0) begin n_fail++; $display("FAIL midrst pulses: release %b tx_done %b want 0 0", rel_a, txd_a); end
        if (txd_q.size() !== 0) begin n_fail++; $display("FAIL midrst partial tx_done: got %0d want 0", txd_q.size()); end
        repeat (2) @(posedge clk);
        #1 clear_q();
        rst = 1'b0;
        load_frame(2);
        start_frame(t, ok);
        wait_txd(1, 4000, done);
        if (!ok || !done) begin n_fail++; $display("FAIL postrst progress: accept %b done %b want 1 1", ok, done); end
        if (stream_mm() !== 0) begin n_fail++; $display("FAIL postrst stream: %0d mismatches want 0", stream_mm()); end
        if (txd_q.size() !== 1) begin n_fail++; $display("FAIL postrst tx_done count: got %0d want 1", txd_q.size()); end
    endtask

    initial begin
        fork
            drive_ready();
        join_none
        test_reset();
        test_all_ones();
        test_boundary();
        test_backpressure();
        test_stall();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
